// File: rtl/clock_timebase_if.sv
// Button inputs and display-side outputs of the clock timebase.
// master: whoever drives the buttons and consumes the display fields.
// slave : the timebase itself.
interface clock_timebase_if;
  logic        btn_mode;
  logic        btn_inc;
  logic [11:0] data_show;
  logic [2:0]  byte_status;
  logic [1:0]  mode;
  logic        sec_tick;

  modport master (
    output btn_mode,
    output btn_inc,
    input  data_show,
    input  byte_status,
    input  mode,
    input  sec_tick
  );

  modport slave (
    input  btn_mode,
    input  btn_inc,
    output data_show,
    output byte_status,
    output mode,
    output sec_tick
  );
endinterface

// File: rtl/clock_timebase.sv
// Clock timebase: keeps hh:mm:ss, lets the user set hours/minutes with two
// debounced push buttons, and produces the display fields plus scan phase.
// Button index 0 is "mode", index 1 is "inc".
module clock_timebase #(
  parameter int TICK_DIV        = 10000000,
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clock,
  input  logic              reset,
  clock_timebase_if.slave   bus
);

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_e;

  // Counter widths; a divide-by-one still needs a 1-bit register.
  localparam int TW = (TICK_DIV > 1)        ? $clog2(TICK_DIV)        : 1;
  localparam int SW = (SCAN_DIV > 1)        ? $clog2(SCAN_DIV)        : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  localparam int BTN_MODE = 0;
  localparam int BTN_INC  = 1;

  // Increment with wrap; anything at or above the last legal value
  // returns to zero so a corrupted field can never run away.
  function automatic logic [5:0] f_wrap_inc(input logic [5:0] i_val,
                                            input logic [5:0] i_last);
    logic [5:0] w_res;
    if (i_val >= i_last) begin
      w_res = 6'd0;
    end else begin
      w_res = i_val + 6'd1;
    end
    return w_res;
  endfunction

  // Button path
  logic [1:0]    w_btn_raw;
  logic [1:0]    r_meta;
  logic [1:0]    r_sync;
  logic [1:0]    r_deb;
  logic [DW-1:0] r_deb_cnt [2];
  logic [1:0]    w_press;
  logic          w_mode_evt;
  logic          w_inc_evt;

  // Timekeeping
  mode_e         r_mode;
  logic [TW-1:0] r_presc;
  logic [5:0]    r_seconds;
  logic [5:0]    r_minutes;
  logic [5:0]    r_hours;
  logic          r_sec_tick;
  logic          w_tick;
  logic          w_sec_carry;
  logic          w_min_carry;

  // Scan
  logic [SW-1:0] r_scan_div;
  logic [2:0]    r_byte_status;

  assign w_btn_raw = {bus.btn_inc, bus.btn_mode};

  // Two-flop synchronizers bringing the raw buttons into the clock domain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_meta <= 2'b00;
      r_sync <= 2'b00;
    end else begin
      r_meta <= w_btn_raw;
      r_sync <= r_meta;
    end
  end

  // Debounce: count consecutive disagreeing samples, flip level at the limit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_deb <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] != r_deb[i]) begin
          if (r_deb_cnt[i] == DEB_LAST) begin
            r_deb[i]     <= r_sync[i];
            r_deb_cnt[i] <= '0;
          end else begin
            r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
          end
        end else begin
          r_deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Press event fires in the cycle the debounced level is about to rise,
  // so the FSM reacts on the same edge the debounced level flips.
  always_comb begin
    w_press = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (r_sync[i] && !r_deb[i] && (r_deb_cnt[i] == DEB_LAST)) begin
        w_press[i] = 1'b1;
      end else begin
        w_press[i] = 1'b0;
      end
    end
  end

  // Mode press has priority; a coincident inc press is dropped.
  always_comb begin
    w_mode_evt = w_press[BTN_MODE];
    if (w_press[BTN_MODE]) begin
      w_inc_evt = 1'b0;
    end else begin
      w_inc_evt = w_press[BTN_INC];
    end
  end

  // A tick is accepted only in RUN and only if we are not leaving RUN now.
  always_comb begin
    w_tick = 1'b0;
    if ((r_mode == MODE_RUN) && (r_presc == TICK_LAST) && !w_mode_evt) begin
      w_tick = 1'b1;
    end else begin
      w_tick = 1'b0;
    end
  end

  // Carry chain flags, evaluated on the pre-tick values so the whole
  // 23:59:59 -> 00:00:00 rollover happens on a single edge.
  always_comb begin
    w_sec_carry = 1'b0;
    w_min_carry = 1'b0;
    if (r_seconds >= 6'd59) begin
      w_sec_carry = 1'b1;
      if (r_minutes >= 6'd59) begin
        w_min_carry = 1'b1;
      end else begin
        w_min_carry = 1'b0;
      end
    end else begin
      w_sec_carry = 1'b0;
      w_min_carry = 1'b0;
    end
  end

  // Mode FSM together with prescaler, time fields and the tick pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mode     <= MODE_RUN;
      r_presc    <= '0;
      r_seconds  <= 6'd0;
      r_minutes  <= 6'd0;
      r_hours    <= 6'd0;
      r_sec_tick <= 1'b0;
    end else begin
      r_sec_tick <= w_tick;
      case (r_mode)
        MODE_RUN: begin
          if (w_mode_evt) begin
            r_mode    <= MODE_SET_HOUR;
            r_presc   <= '0;
            r_seconds <= 6'd0;
          end else if (w_tick) begin
            r_presc   <= '0;
            r_seconds <= f_wrap_inc(r_seconds, 6'd59);
            if (w_sec_carry) begin
              r_minutes <= f_wrap_inc(r_minutes, 6'd59);
            end else begin
              r_minutes <= r_minutes;
            end
            if (w_min_carry) begin
              r_hours <= f_wrap_inc(r_hours, 6'd23);
            end else begin
              r_hours <= r_hours;
            end
          end else begin
            r_presc <= r_presc + TW'(1);
          end
        end
        MODE_SET_HOUR: begin
          r_presc   <= '0;
          r_seconds <= 6'd0;
          if (w_mode_evt) begin
            r_mode <= MODE_SET_MIN;
          end else if (w_inc_evt) begin
            r_hours <= f_wrap_inc(r_hours, 6'd23);
          end else begin
            r_hours <= r_hours;
          end
        end
        MODE_SET_MIN: begin
          r_presc   <= '0;
          r_seconds <= 6'd0;
          if (w_mode_evt) begin
            r_mode <= MODE_RUN;
          end else if (w_inc_evt) begin
            r_minutes <= f_wrap_inc(r_minutes, 6'd59);
          end else begin
            r_minutes <= r_minutes;
          end
        end
        default: begin
          r_mode    <= MODE_RUN;
          r_presc   <= '0;
          r_seconds <= 6'd0;
        end
      endcase
    end
  end

  // Free-running scan divider stepping the digit phase 0..7.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_scan_div    <= '0;
      r_byte_status <= 3'd0;
    end else begin
      if (r_scan_div == SCAN_LAST) begin
        r_scan_div    <= '0;
        r_byte_status <= r_byte_status + 3'd1;
      end else begin
        r_scan_div    <= r_scan_div + SW'(1);
        r_byte_status <= r_byte_status;
      end
    end
  end

  assign bus.data_show   = {r_hours, r_minutes};
  assign bus.byte_status = r_byte_status;
  assign bus.mode        = r_mode;
  assign bus.sec_tick    = r_sec_tick;

endmodule

// File: tb/tb_clock_timebase.sv
// Self-checking bench for clock_timebase with small divider values.
// The reference model tracks time as seconds-of-day and decides button
// events from a sliding window of raw samples.
module tb_clock_timebase;

  localparam int TICK = 4;
  localparam int SCAN = 2;
  localparam int DEB  = 3;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  clock_timebase_if u_if ();

  clock_timebase #(
    .TICK_DIV        (TICK),
    .SCAN_DIV        (SCAN),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  int       m_mode;   // 0 RUN, 1 SET_HOUR, 2 SET_MIN
  int       m_h, m_mi, m_s;
  int       m_run;    // edges spent in RUN since entering it
  int       m_edges;  // edges since reset release
  bit       m_tick;
  bit       m_deb [2];
  bit [7:0] m_hist [2];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_h = 0; m_mi = 0; m_s = 0;
      m_run = 0; m_edges = 0; m_tick = 1'b0;
      for (int b = 0; b < 2; b++) begin
        m_deb[b]  = 1'b0;
        m_hist[b] = 8'd0;
      end
    end else begin
      bit ev [2];
      bit stable;
      int t;
      m_edges++;
      for (int b = 0; b < 2; b++) begin
        m_hist[b] = {m_hist[b][6:0], (b == 0) ? u_if.btn_mode : u_if.btn_inc};
        // The synchronizer delays samples by two edges; the level flips
        // once DEB consecutive delayed samples disagree with it.
        stable = 1'b1;
        for (int k = 2; k <= DEB + 1; k++) begin
          if (m_hist[b][k] == m_deb[b]) stable = 1'b0;
        end
        ev[b] = 1'b0;
        if (stable) begin
          m_deb[b] = !m_deb[b];
          ev[b]    = m_deb[b];
        end
      end
      m_tick = 1'b0;
      if (ev[0]) begin
        if (m_mode == 0) begin m_mode = 1; m_s = 0; end
        else if (m_mode == 1) m_mode = 2;
        else begin m_mode = 0; m_run = 0; end
      end else if (m_mode == 0) begin
        m_run++;
        if (m_run % TICK == 0) begin
          t    = (m_h * 3600 + m_mi * 60 + m_s + 1) % 86400;
          m_h  = t / 3600;
          m_mi = (t / 60) % 60;
          m_s  = t % 60;
          m_tick = 1'b1;
        end
      end else if (ev[1]) begin
        if (m_mode == 1) m_h = (m_h + 1) % 24;
        else m_mi = (m_mi + 1) % 60;
      end
    end
  end

  function automatic logic [11:0] exp_ds();
    return 12'(m_h * 64 + m_mi);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    u_if.btn_mode = 1'b0;
    u_if.btn_inc  = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic press(input bit is_mode, input int hold, input int gap);
    @(negedge clock);
    if (is_mode) u_if.btn_mode = 1'b1; else u_if.btn_inc = 1'b1;
    repeat (hold) @(negedge clock);
    u_if.btn_mode = 1'b0;
    u_if.btn_inc  = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    u_if.btn_mode = 1'b0;
    u_if.btn_inc  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (u_if.data_show !== 12'd0) begin failures++; $display("FAIL reset_data_show got=%0d exp=0", u_if.data_show); end
    checks++; if (u_if.byte_status !== 3'd0) begin failures++; $display("FAIL reset_byte_status got=%0d exp=0", u_if.byte_status); end
    checks++; if (u_if.mode !== 2'd0) begin failures++; $display("FAIL reset_mode got=%0d exp=0", u_if.mode); end
    checks++; if (u_if.sec_tick !== 1'b0) begin failures++; $display("FAIL reset_sec_tick got=%0d exp=0", u_if.sec_tick); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_run_hour();
    int pulses = 0;
    for (int c = 0; c < 4 * 3600; c++) begin
      @(posedge clock); #1;
      checks++;
      if (u_if.sec_tick !== m_tick) begin failures++; $display("FAIL run_sec_tick cyc=%0d got=%0d exp=%0d", c, u_if.sec_tick, m_tick); end
      if (u_if.sec_tick === 1'b1) pulses++;
    end
    checks++; if (pulses != 3600) begin failures++; $display("FAIL run_pulse_count got=%0d exp=3600", pulses); end
    checks++; if (u_if.data_show !== 12'h040) begin failures++; $display("FAIL run_hour_data_show got=%h exp=040", u_if.data_show); end
    checks++; if (u_if.mode !== 2'd0) begin failures++; $display("FAIL run_hour_mode got=%0d exp=0", u_if.mode); end
  endtask

  task automatic test_set_sequence();
    do_reset();
    @(negedge clock);
    u_if.btn_mode = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    checks++; if (u_if.mode !== 2'd0) begin failures++; $display("FAIL mode_early got=%0d exp=0", u_if.mode); end
    @(posedge clock); #1;
    checks++; if (u_if.mode !== 2'd1) begin failures++; $display("FAIL mode_latency5 got=%0d exp=1", u_if.mode); end
    repeat (5) @(negedge clock);
    u_if.btn_mode = 1'b0;
    repeat (6) @(negedge clock);
    for (int i = 0; i < 3; i++) press(1'b0, 4 + $urandom_range(0, 4), 6 + $urandom_range(0, 3));
    checks++; if (u_if.data_show !== 12'(3 * 64)) begin failures++; $display("FAIL set_hours3 got=%h exp=%h", u_if.data_show, 12'(3 * 64)); end
    press(1'b1, 6, 6);
    checks++; if (u_if.mode !== 2'd2) begin failures++; $display("FAIL mode_set_min got=%0d exp=2", u_if.mode); end
    for (int i = 0; i < 61; i++) press(1'b0, 4 + $urandom_range(0, 3), 6);
    checks++; if (u_if.data_show !== 12'(3 * 64 + 1)) begin failures++; $display("FAIL set_min_wrap got=%h exp=%h", u_if.data_show, 12'(3 * 64 + 1)); end
    press(1'b1, 6, 6);
    checks++; if (u_if.mode !== 2'd0) begin failures++; $display("FAIL mode_back_run got=%0d exp=0", u_if.mode); end
    checks++; if (u_if.data_show !== exp_ds()) begin failures++; $display("FAIL set_model got=%h exp=%h", u_if.data_show, exp_ds()); end
  endtask

  task automatic test_rollover();
    int bad = 0;
    do_reset();
    press(1'b1, 6, 6);
    for (int i = 0; i < 23; i++) press(1'b0, 5, 6);
    press(1'b1, 6, 6);
    for (int i = 0; i < 59; i++) press(1'b0, 5, 6);
    press(1'b1, 6, 0);
    #1;
    checks++; if (u_if.data_show !== 12'(23 * 64 + 59)) begin failures++; $display("FAIL preload got=%h exp=%h", u_if.data_show, 12'(23 * 64 + 59)); end
    for (int c = 0; c < 240; c++) begin
      @(posedge clock); #1;
      if (u_if.data_show[11:6] > 6'd23 || u_if.data_show[5:0] > 6'd59) bad++;
      checks++;
      if (u_if.data_show !== exp_ds()) begin failures++; $display("FAIL rollover_track cyc=%0d got=%h exp=%h", c, u_if.data_show, exp_ds()); end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL rollover_glitch got=%0d exp=0", bad); end
    checks++; if (u_if.data_show !== 12'd0) begin failures++; $display("FAIL rollover_final got=%h exp=000", u_if.data_show); end
  endtask

  task automatic test_bounce();
    do_reset();
    press(1'b1, 6, 6);
    for (int c = 0; c < 20; c += 2) begin
      @(negedge clock);
      u_if.btn_inc = ~u_if.btn_inc;
      @(negedge clock);
    end
    u_if.btn_inc = 1'b1;
    repeat (30) @(negedge clock);
    checks++; if (u_if.data_show !== 12'(1 * 64)) begin failures++; $display("FAIL bounce_single_inc got=%h exp=%h", u_if.data_show, 12'(64)); end
    u_if.btn_inc = 1'b0;
    repeat (8) @(negedge clock);
    checks++; if (u_if.data_show !== exp_ds()) begin failures++; $display("FAIL bounce_model got=%h exp=%h", u_if.data_show, exp_ds()); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    repeat ($urandom_range(0, 5)) @(negedge clock);
    @(negedge clock);
    u_if.btn_mode = 1'b1;
    u_if.btn_inc  = 1'b1;
    repeat (10) @(negedge clock);
    u_if.btn_mode = 1'b0;
    u_if.btn_inc  = 1'b0;
    repeat (6) @(negedge clock);
    checks++; if (u_if.mode !== 2'd1) begin failures++; $display("FAIL simul_mode got=%0d exp=1", u_if.mode); end
    checks++; if (u_if.data_show[11:6] !== 6'd0) begin failures++; $display("FAIL simul_hours got=%0d exp=0", u_if.data_show[11:6]); end
  endtask

  task automatic test_reset_mid_debounce();
    do_reset();
    press(1'b1, 6, 6);
    press(1'b1, 6, 6);
    checks++; if (u_if.mode !== 2'd2) begin failures++; $display("FAIL mid_pre_mode got=%0d exp=2", u_if.mode); end
    u_if.btn_inc = 1'b1;
    repeat (3) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    checks++; if (u_if.data_show !== 12'd0 || u_if.mode !== 2'd0 || u_if.byte_status !== 3'd0 || u_if.sec_tick !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=%h/%0d/%0d/%0d exp=0/0/0/0", u_if.data_show, u_if.mode, u_if.byte_status, u_if.sec_tick);
    end
    u_if.btn_inc = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clock); #1;
      checks++;
      if (u_if.byte_status !== 3'((k / 2) % 8)) begin failures++; $display("FAIL scan_step k=%0d got=%0d exp=%0d", k, u_if.byte_status, (k / 2) % 8); end
    end
    checks++; if (u_if.data_show !== 12'd0) begin failures++; $display("FAIL pending_discarded got=%h exp=000", u_if.data_show); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if ($urandom_range(0, 7) == 0) u_if.btn_mode = ~u_if.btn_mode;
      if ($urandom_range(0, 5) == 0) u_if.btn_inc  = ~u_if.btn_inc;
      @(posedge clock); #1;
      checks++;
      if (u_if.data_show !== exp_ds() || u_if.mode !== 2'(m_mode) || u_if.sec_tick !== m_tick || u_if.byte_status !== 3'((m_edges / SCAN) % 8)) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h/%0d/%0d/%0d exp=%h/%0d/%0d/%0d", c, u_if.data_show, u_if.mode, u_if.sec_tick, u_if.byte_status,
                 exp_ds(), m_mode, m_tick, (m_edges / SCAN) % 8);
      end
    end
    u_if.btn_mode = 1'b0;
    u_if.btn_inc  = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    u_if.btn_mode = 1'b0;
    u_if.btn_inc  = 1'b0;
    test_reset();
    test_run_hour();
    test_set_sequence();
    test_rollover();
    test_bounce();
    test_simultaneous();
    test_reset_mid_debounce();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_timebase.md
Name: clock_timebase

Overview:
- Timekeeping and scan-control stage directly upstream of the seven-segment display driver.
- Holds an hours:minutes:seconds time, lets the user set hours and minutes with two push buttons, and produces the two 6-bit display fields plus the 3-bit digit-scan phase the driver consumes.
- Output packing: data_show[11:6] = hours, data_show[5:0] = minutes.

Parameters:
- TICK_DIV, 10000000, clock cycles per 1 s tick (≥2).
- SCAN_DIV, 1000, clock cycles per scan-phase step (≥1).
- DEBOUNCE_CYCLES, 50000, consecutive stable synchronized samples needed to accept a button level change (≥1).

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- btn_mode  input  1  raw mode button, active-high, asynchronous to clock.
- btn_inc  input  1  raw increment button, active-high, asynchronous to clock.
- data_show  output  12  [11:6] hours 0..23, [5:0] minutes 0..59, plain binary.
- byte_status  output  3  digit-scan phase 0..7 for the display driver.
- mode  output  2  0 = RUN, 1 = SET_HOUR, 2 = SET_MIN (3 is never driven).
- sec_tick  output  1  one-cycle pulse on each accepted 1 s tick.

Behaviour:
- Reset (reset=0, async): all counters, synchronizers and debounce state cleared; hours=0, minutes=0, seconds=0, byte_status=0, mode=RUN, sec_tick=0. Debounced button levels reset to 0.
- Input sync: each button passes through a 2-flop synchronizer.
- Debounce: a per-button counter counts cycles where the synchronized level differs from the debounced level.
  - The debounced level flips when the count reaches DEBOUNCE_CYCLES.
  - Any cycle with agreeing levels clears the count.
  - A press event is a 1-cycle pulse on the debounced 0->1 edge. Release generates no event.
  - Latency, raw edge to event: 2 + DEBOUNCE_CYCLES cycles.
- Prescaler: counts 0..TICK_DIV-1 in RUN only.
  - At TICK_DIV-1 it wraps to 0, and sec_tick=1 for that cycle (registered, visible the next cycle).
- Time chain on tick:
  - seconds 59 -> 0 with carry, else +1.
  - minutes 59 -> 0 with carry, else +1.
  - hours 23 -> 0, else +1.
  - The carry ripples in the same cycle, so 23:59:59 -> 00:00:00 in one step.
- FSM, mode press transitions: RUN -> SET_HOUR -> SET_MIN -> RUN.
  - On leaving RUN: prescaler and seconds cleared and held at 0 while in SET states. No sec_tick is generated in SET states.
  - On returning to RUN: counting restarts from prescaler=0, seconds=0, so the first tick comes TICK_DIV cycles later.
- Increment press:
  - In SET_HOUR: hours +1, 23 wraps to 0, minutes untouched.
  - In SET_MIN: minutes +1, 59 wraps to 0, no carry into hours.
  - In RUN: ignored.
- Simultaneous mode and inc events in the same cycle: mode wins and inc is dropped.
- Holding a button produces exactly one event. No auto-repeat.
- Scan counter: free-running in all modes.
  - A divider of SCAN_DIV cycles advances byte_status by 1 per period; 7 wraps to 0.
  - byte_status changes only on divider wrap.
- Outputs are registered. data_show updates the cycle after the tick or inc event that changes it.
- Reset asserted mid-operation, including during debounce or a SET state: immediate return to reset values, and any pending button state is discarded.

Test Plan (TICK_DIV=4, SCAN_DIV=2, DEBOUNCE_CYCLES=3):
- Release reset, buttons low, run 4*60*60 cycles -> data_show={6'd1,6'd0}, sec_tick pulses every 4 cycles, mode=0.
- Preload via SET to 23:59, return to RUN, run 240 cycles -> data_show={6'd0,6'd0} after rollover, no glitch through 24 or 60.
- Mode press (held 10 cycles) -> mode=1 exactly 5 cycles after raw edge. Three inc presses -> hours=3. Mode press -> mode=2. 61 inc presses -> minutes=1, hours still 3. Mode press -> mode=0.
- Bounce btn_inc high/low every 2 cycles for 20 cycles in SET_HOUR, then hold high -> exactly one increment.
- Raise btn_mode and btn_inc on the same cycle from RUN -> mode=1, hours unchanged.
- Assert reset in SET_MIN mid-debounce -> all outputs 0 asynchronously. After release, byte_status steps 0,1,...,7,0 every 2 cycles.
